// File: rtl/mips_mc_controller.sv
`default_nettype none
// ============================================================================
// mips_mc_controller : multicycle MIPS control FSM, ALU decoder, instret count
// Revision: 1.0
// ============================================================================
module mips_mc_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pcen,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regwrite,
  output logic             iord,
  output logic             memtoreg,
  output logic             regdst,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [2:0]       alucontrol,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t cur_state;
  state_t next_state;
  logic   pcwrite;
  logic   branch;
  logic   retire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= S_FETCH;
    end else begin
      cur_state <= next_state;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + CNT_W'(1);
    end
  end

  assign state = cur_state;

  always_comb begin
    next_state = S_FETCH;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    retire     = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = 3'b000;
    illegal_op = 1'b0;

    case (cur_state)
      S_FETCH: begin
        alusrcb    = 2'b01;
        alucontrol = ALU_ADD;
        irwrite    = 1'b1;
        pcwrite    = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is computed here so BRANCH only has to compare.
        alusrcb    = 2'b11;
        alucontrol = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXECUTE;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JUMP;
          default:      illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
        next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord       = 1'b1;
        next_state = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        retire   = 1'b1;
      end
      S_EXECUTE: begin
        alusrca    = 1'b1;
        next_state = S_ALUWB;
        case (funct)
          6'b100000: alucontrol = ALU_ADD;
          6'b100010: alucontrol = ALU_SUB;
          6'b100100: alucontrol = ALU_AND;
          6'b100101: alucontrol = ALU_OR;
          6'b101010: alucontrol = ALU_SLT;
          default: begin
            alucontrol = ALU_ADD;
            illegal_op = 1'b1;
            next_state = S_FETCH;
          end
        endcase
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        retire     = 1'b1;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
        next_state = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        retire  = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase

    pcen = pcwrite | (branch & zero);

    // Keep the datapath quiet for the whole time reset is held.
    if (reset) begin
      pcen       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regwrite   = 1'b0;
      iord       = 1'b0;
      memtoreg   = 1'b0;
      regdst     = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      alucontrol = 3'b000;
      illegal_op = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_controller.sv
`default_nettype none
// ============================================================================
// tb_mips_mc_controller : scoreboard bench, per-cycle expected control vectors
// Revision: 1.0
// ============================================================================
module tb_mips_mc_controller;

  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic          zero;
  logic          pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0]    alusrcb, pcsrc;
  logic [2:0]    alucontrol;
  logic          illegal_op;
  logic [CW-1:0] instret;
  logic [3:0]    state;

  mips_mc_controller #(.CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .pcen       (pcen),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .illegal_op (illegal_op),
    .instret    (instret),
    .state      (state)
  );

  typedef struct packed {
    logic [3:0]    st;
    logic          pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0]    alusrcb, pcsrc;
    logic [2:0]    alu;
    logic          ill;
    logic [CW-1:0] cnt;
  } rec_t;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_ADDI = 4, K_J = 5, K_BAD = 6;

  rec_t          exp_q[$];
  rec_t          act;
  rec_t          zero_rec;
  int            n_checks;
  int            n_fail;
  logic          run;
  logic [CW-1:0] model_cnt;
  logic [5:0]    legal_fn_tab [5];

  assign act = {state, pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
                alusrcb, pcsrc, alucontrol, illegal_op, instret};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input rec_t e, input string nm);
    n_checks++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%h required=%h (state %0d vs %0d)",
               nm, $time, act, e, act.st, e.st);
    end
  endtask

  // Monitor: every sampled cycle is one scoreboard entry, or all-quiet under reset.
  always @(negedge clk) begin
    if (reset) begin
      check(zero_rec, "reset_outputs");
    end else if (run) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow t=%0t actual=%h required=none", $time, act);
      end else begin
        check(exp_q.pop_front(), "cycle_outputs");
      end
    end
  end

  // Control vector a given microstep must show, straight from the state table.
  function automatic rec_t step_rec(input int s, input logic [2:0] alu, input logic ill,
                                    input logic z);
    rec_t r;
    r     = '0;
    r.st  = 4'(s);
    r.cnt = model_cnt;
    case (s)
      0:  begin r.alusrcb = 2'b01; r.alu = 3'b010; r.irwrite = 1'b1; r.pcen = 1'b1; end
      1:  begin r.alusrcb = 2'b11; r.alu = 3'b010; r.ill = ill; end
      2:  begin r.alusrca = 1'b1; r.alusrcb = 2'b10; r.alu = 3'b010; end
      3:  r.iord = 1'b1;
      4:  begin r.memtoreg = 1'b1; r.regwrite = 1'b1; end
      5:  begin r.iord = 1'b1; r.memwrite = 1'b1; end
      6:  begin r.alusrca = 1'b1; r.alu = alu; r.ill = ill; end
      7:  begin r.regdst = 1'b1; r.regwrite = 1'b1; end
      8:  begin r.alusrca = 1'b1; r.alu = 3'b110; r.pcsrc = 2'b01; r.pcen = z; end
      9:  begin r.alusrca = 1'b1; r.alusrcb = 2'b10; r.alu = 3'b010; end
      10: r.regwrite = 1'b1;
      11: begin r.pcsrc = 2'b10; r.pcen = 1'b1; end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Called with the DUT in FETCH, 1ns after a rising edge; returns likewise.
  task automatic issue(input int kind, input logic [5:0] fn, input logic z);
    int         steps[$];
    logic [2:0] a;
    logic       fn_ok;
    logic       ill;
    logic [5:0] op;
    fn_ok = 1'b1;
    a     = 3'b010;
    case (fn)
      6'b100000: a = 3'b010;
      6'b100010: a = 3'b110;
      6'b100100: a = 3'b000;
      6'b100101: a = 3'b001;
      6'b101010: a = 3'b111;
      default:   fn_ok = 1'b0;
    endcase
    case (kind)
      K_LW:   begin op = 6'b100011; steps = '{0, 1, 2, 3, 4}; end
      K_SW:   begin op = 6'b101011; steps = '{0, 1, 2, 5}; end
      K_R: begin
        op = 6'b000000;
        if (fn_ok) steps = '{0, 1, 6, 7};
        else       steps = '{0, 1, 6};
      end
      K_BEQ:  begin op = 6'b000100; steps = '{0, 1, 8}; end
      K_ADDI: begin op = 6'b001000; steps = '{0, 1, 9, 10}; end
      K_J:    begin op = 6'b000010; steps = '{0, 1, 11}; end
      default: begin
        do op = 6'($urandom);
        while (op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010});
        steps = '{0, 1};
      end
    endcase
    opcode = op;
    funct  = fn;
    zero   = z;
    foreach (steps[i]) begin
      ill = ((kind == K_BAD) && (steps[i] == 1)) || ((kind == K_R) && !fn_ok && (steps[i] == 6));
      exp_q.push_back(step_rec(steps[i], a, ill, z));
    end
    repeat (steps.size()) @(posedge clk);
    #1;
    if (!((kind == K_BAD) || ((kind == K_R) && !fn_ok))) model_cnt = model_cnt + 1'b1;
  endtask

  task automatic reset_mid_execute();
    opcode = 6'b000000;
    funct  = 6'b100000;
    zero   = 1'b0;
    exp_q.push_back(step_rec(0, 3'b010, 1'b0, 1'b0));
    exp_q.push_back(step_rec(1, 3'b010, 1'b0, 1'b0));
    exp_q.push_back(step_rec(6, 3'b010, 1'b0, 1'b0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    model_cnt = '0;
  endtask

  initial begin
    legal_fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    zero_rec  = '0;
    n_checks  = 0;
    n_fail    = 0;
    run       = 1'b0;
    model_cnt = '0;
    reset     = 1'b1;
    opcode    = '0;
    funct     = '0;
    zero      = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    run = 1'b1;

    issue(K_LW,   6'b000000, 1'b0);
    issue(K_R,    6'b100010, 1'b0);
    issue(K_R,    6'b101010, 1'b1);
    issue(K_R,    6'b100101, 1'b0);
    issue(K_BEQ,  6'b000000, 1'b1);
    issue(K_BEQ,  6'b000000, 1'b0);
    issue(K_BAD,  6'b000000, 1'b0);
    issue(K_R,    6'b000000, 1'b0);
    issue(K_SW,   6'b000000, 1'b1);
    issue(K_ADDI, 6'b000000, 1'b0);
    for (int i = 0; i < 16; i++) issue(K_J, 6'($urandom), 1'($urandom));
    reset_mid_execute();

    for (int i = 0; i < 300; i++) begin
      int         k;
      logic [5:0] f;
      k = int'($urandom_range(0, 6));
      if ($urandom_range(0, 3) != 0) f = legal_fn_tab[$urandom_range(0, 4)];
      else                           f = 6'($urandom);
      issue(k, f, 1'($urandom));
    end

    run = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d entries left required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
